// File: rtl/mcs51_serial.sv
// MCS-51 serial port (SCON/SBUF at 0x98/0x99) as an SFR-bus responder, mode 1 only.
// Handshake: sfr_we is a single-cycle write strobe; reads are combinational on sfr_addr.
module mcs51_serial #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sfr_addr,
  input  logic       sfr_we,
  input  logic [7:0] sfr_wdata,
  output logic [7:0] sfr_rdata,
  output logic       sfr_hit,
  input  logic       baud_tick,
  input  logic       rxd,
  output logic       txd,
  output logic       ser_irq,
  output logic       rx_overrun
);

  localparam logic [7:0] SCON_ADDR = 8'h98;
  localparam logic [7:0] SBUF_ADDR = 8'h99;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]             scon;
  logic [7:0]             scon_next;
  logic [7:0]             rx_sbuf;
  logic [1:0]             tx_state;
  logic [CW-1:0]          tx_cnt;
  logic [2:0]             tx_bit;
  logic [7:0]             tx_shift;
  logic [1:0]             rx_state;
  logic [CW-1:0]          rx_cnt;
  logic [CW-1:0]          rx_cnt_next;
  logic [2:0]             rx_bit;
  logic [7:0]             rx_shift;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   rx_prev;
  logic                   rx_fall;
  logic                   mode1;
  logic                   rx_en;
  logic                   scon_wr;
  logic                   sbuf_wr;
  logic                   tx_bit_end;
  logic                   ti_set;
  logic                   rx_mid;
  logic                   rx_stop_mid;
  logic                   rx_accept;
  logic                   rx_drop_ovr;

  assign mode1   = (scon[7:6] == 2'b01);
  assign rx_en   = mode1 && scon[4];
  assign scon_wr = sfr_we && (sfr_addr == SCON_ADDR);
  assign sbuf_wr = sfr_we && (sfr_addr == SBUF_ADDR);

  always_comb begin
    sfr_rdata = 8'h00;
    sfr_hit   = 1'b0;
    case (sfr_addr)
      SCON_ADDR: begin
        sfr_rdata = scon;
        sfr_hit   = 1'b1;
      end
      SBUF_ADDR: begin
        sfr_rdata = rx_sbuf;
        sfr_hit   = 1'b1;
      end
      default: ;
    endcase
  end

  assign ser_irq = scon[1] | scon[0];

  // Transmitter
  assign tx_bit_end = baud_tick && (tx_cnt == CNT_LAST);
  assign ti_set     = mode1 && (tx_state == ST_DATA) && tx_bit_end && (tx_bit == 3'd7);

  always_comb begin
    txd = 1'b1;
    case (tx_state)
      ST_START: txd = 1'b0;
      ST_DATA:  txd = tx_shift[0];
      default:  txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else if (!mode1) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (sbuf_wr) begin
            tx_shift <= sfr_wdata;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick) tx_cnt <= tx_cnt + CW'(1);
          if (tx_bit_end) tx_state <= ST_DATA;
        end
        ST_DATA: begin
          if (baud_tick) tx_cnt <= tx_cnt + CW'(1);
          if (tx_bit_end) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_state <= ST_STOP;
          end
        end
        default: begin
          if (baud_tick) tx_cnt <= tx_cnt + CW'(1);
          if (tx_bit_end) tx_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Receiver: synchronizer idles high so reset never looks like a start edge
  assign rx_s    = sync[SYNC_STAGES-1];
  assign rx_fall = rx_prev && !rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], rxd};
      rx_prev <= rx_s;
    end
  end

  // Counter wraps at OVERSAMPLE; the sample point is the tick that brings it to the middle
  assign rx_cnt_next = rx_cnt + CW'(1);
  assign rx_mid      = baud_tick && (rx_cnt_next == CNT_MID);
  assign rx_stop_mid = rx_en && (rx_state == ST_STOP) && rx_mid;
  assign rx_accept   = rx_stop_mid && !scon[0] && (!scon[5] || rx_s);
  assign rx_drop_ovr = rx_stop_mid && scon[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (!rx_en) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      case (rx_state)
        ST_IDLE: begin
          if (rx_fall) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick) rx_cnt <= rx_cnt_next;
          if (rx_mid) begin
            rx_bit   <= '0;
            rx_state <= rx_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) rx_cnt <= rx_cnt_next;
          if (rx_mid) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
          end
        end
        default: begin
          if (baud_tick) rx_cnt <= rx_cnt_next;
          if (rx_mid) rx_state <= ST_IDLE;
        end
      endcase
    end
  end

  // CPU write lands first, hardware flag sets are ORed on top so they win a collision
  always_comb begin
    scon_next = scon;
    if (scon_wr) scon_next = sfr_wdata;
    if (ti_set) scon_next[1] = 1'b1;
    if (rx_accept) begin
      scon_next[0] = 1'b1;
      scon_next[2] = rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scon       <= 8'h00;
      rx_sbuf    <= 8'h00;
      rx_overrun <= 1'b0;
    end else begin
      scon       <= scon_next;
      rx_overrun <= rx_drop_ovr;
      if (rx_accept) rx_sbuf <= rx_shift;
    end
  end

endmodule

// File: tb/tb_mcs51_serial.sv
// Directed bench for mcs51_serial: SFR reads and txd bit streams are scored against expected queues.
module tb_mcs51_serial;

  logic       clk;
  logic       rst;
  logic [7:0] sfr_addr;
  logic       sfr_we;
  logic [7:0] sfr_wdata;
  logic [7:0] sfr_rdata;
  logic       sfr_hit;
  logic       baud_tick;
  logic       rxd;
  logic       txd;
  logic       ser_irq;
  logic       rx_overrun;

  int total = 0;
  int bad   = 0;
  int ov_cnt = 0;
  logic rd_req = 1'b0;
  logic tx_mon_en = 1'b1;
  logic [8:0] rd_exp_q[$];
  string      rd_name_q[$];
  logic [1:0] tx_exp_q[$];
  logic [1:0] div = 2'd0;

  mcs51_serial #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sfr_addr(sfr_addr), .sfr_we(sfr_we),
    .sfr_wdata(sfr_wdata), .sfr_rdata(sfr_rdata), .sfr_hit(sfr_hit),
    .baud_tick(baud_tick), .rxd(rxd), .txd(txd), .ser_irq(ser_irq),
    .rx_overrun(rx_overrun)
  );

  // Clock / reset / baud tick (one tick every 4 clocks, 64 clocks per bit)
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = div + 2'd1;
      baud_tick = (div == 2'd0);
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks: everything changes 2 time units after a rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
    sfr_addr  = a;
    sfr_wdata = d;
    sfr_we    = 1'b1;
    step();
    sfr_we    = 1'b0;
    sfr_addr  = 8'h00;
  endtask

  task automatic sfr_read(input string name, input logic [7:0] a, input logic [7:0] exp, input logic hit);
    sfr_addr = a;
    rd_req   = 1'b1;
    rd_exp_q.push_back({hit, exp});
    rd_name_q.push_back(name);
    step();
    rd_req   = 1'b0;
    sfr_addr = 8'h00;
  endtask

  task automatic expect_pins(input string name, input logic exp_txd, input logic exp_irq);
    @(negedge clk);
    check(name, {14'd0, ser_irq, txd}, {14'd0, exp_irq, exp_txd});
    step();
  endtask

  task automatic push_tx_frame(input logic [7:0] d, input logic irq_during);
    tx_exp_q.push_back({irq_during, 1'b0});
    for (int i = 0; i < 8; i++) tx_exp_q.push_back({irq_during, d[i]});
    tx_exp_q.push_back(2'b11);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    repeat (64) step();
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (64) step();
    end
    rxd = stop;
    repeat (64) step();
    rxd = 1'b1;
    repeat (20) step();
  endtask

  // Scoreboard monitors
  initial begin
    forever begin
      @(negedge clk);
      if (rd_req) begin
        if (rd_exp_q.size() == 0) begin
          check("rd_queue_underflow", 16'd1, 16'd0);
        end else begin
          logic [8:0] e;
          string n;
          e = rd_exp_q.pop_front();
          n = rd_name_q.pop_front();
          check(n, {7'd0, sfr_hit, sfr_rdata}, {7'd0, e});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_mon_en && !rst && txd === 1'b0) begin
        if (tx_exp_q.size() == 0) begin
          check("tx_unexpected_frame", 16'd1, 16'd0);
          repeat (700) @(negedge clk);
        end else begin
          repeat (32) @(negedge clk);
          for (int i = 0; i < 10; i++) begin
            logic [1:0] e;
            if (tx_exp_q.size() == 0) begin
              check("tx_queue_underflow", 16'd1, 16'd0);
              break;
            end
            e = tx_exp_q.pop_front();
            check($sformatf("tx_bit%0d_irq_txd", i), {14'd0, ser_irq, txd}, {14'd0, e});
            if (i < 9) repeat (64) @(negedge clk);
          end
          repeat (40) @(negedge clk);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rx_overrun === 1'b1) ov_cnt++;
    end
  end

  // Directed sequence
  initial begin
    int n;
    int guard;
    int low_cnt;
    rst = 1'b1; sfr_addr = 8'h00; sfr_we = 1'b0; sfr_wdata = 8'h00; rxd = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    expect_pins("reset_txd_irq", 1'b1, 1'b0);
    sfr_read("reset_scon", 8'h98, 8'h00, 1'b1);
    sfr_read("reset_sbuf", 8'h99, 8'h00, 1'b1);
    sfr_read("miss_addr", 8'h10, 8'h00, 1'b0);
    check("reset_overrun", ov_cnt[15:0], 16'd0);

    // TX 0xA5, second write mid-frame ignored
    sfr_write(8'h98, 8'h40);
    push_tx_frame(8'hA5, 1'b0);
    sfr_write(8'h99, 8'hA5);
    repeat (200) step();
    sfr_write(8'h99, 8'hFF);
    repeat (500) step();
    sfr_read("tx_scon_ti", 8'h98, 8'h42, 1'b1);
    expect_pins("tx_idle_irq", 1'b1, 1'b1);

    // RX 0x3C
    sfr_write(8'h98, 8'h50);
    sfr_read("rx_scon_clear", 8'h98, 8'h50, 1'b1);
    expect_pins("rx_irq_clear", 1'b1, 1'b0);
    send_rx(8'h3C, 1'b1);
    sfr_read("rx_sbuf_3c", 8'h99, 8'h3C, 1'b1);
    sfr_read("rx_scon_ri", 8'h98, 8'h55, 1'b1);
    expect_pins("rx_irq_set", 1'b1, 1'b1);
    check("rx_no_overrun", ov_cnt[15:0], 16'd0);

    // Overrun with RI still set
    send_rx(8'h99, 1'b1);
    sfr_read("ovr_sbuf_kept", 8'h99, 8'h3C, 1'b1);
    sfr_read("ovr_scon", 8'h98, 8'h55, 1'b1);
    check("ovr_pulse_cycles", ov_cnt[15:0], 16'd1);

    // False start, then a good 0x55
    sfr_write(8'h98, 8'h50);
    rxd = 1'b0;
    repeat (16) step();
    rxd = 1'b1;
    repeat (200) step();
    sfr_read("fs_scon", 8'h98, 8'h50, 1'b1);
    sfr_read("fs_sbuf", 8'h99, 8'h3C, 1'b1);
    send_rx(8'h55, 1'b1);
    sfr_read("fs_next_sbuf", 8'h99, 8'h55, 1'b1);
    sfr_read("fs_next_scon", 8'h98, 8'h55, 1'b1);

    // SM2 filter: stop=0 dropped silently
    sfr_write(8'h98, 8'h70);
    send_rx(8'h12, 1'b0);
    sfr_read("sm2_scon", 8'h98, 8'h70, 1'b1);
    sfr_read("sm2_sbuf", 8'h99, 8'h55, 1'b1);
    check("sm2_no_overrun", ov_cnt[15:0], 16'd1);

    // Collision: SCON write clearing TI on the clock TI is set
    sfr_write(8'h98, 8'h40);
    push_tx_frame(8'h3C, 1'b0);
    sfr_write(8'h99, 8'h3C);
    n = 0;
    guard = 0;
    forever begin
      if (baud_tick) n++;
      if (n == 144) break;
      guard++;
      if (guard > 2000) begin
        check("collision_tick_timeout", 16'd1, 16'd0);
        break;
      end
      step();
    end
    sfr_write(8'h98, 8'h40);
    repeat (120) step();
    sfr_read("coll_scon", 8'h98, 8'h42, 1'b1);
    expect_pins("coll_irq", 1'b1, 1'b1);

    // Reset mid-TX
    tx_mon_en = 1'b0;
    sfr_write(8'h98, 8'h40);
    sfr_write(8'h99, 8'h00);
    repeat (100) step();
    expect_pins("midtx_txd_low", 1'b0, 1'b0);
    rst = 1'b1;
    step();
    @(negedge clk);
    check("rst_txd_next_cycle", {15'd0, txd}, 16'd1);
    step();
    rst = 1'b0;
    sfr_read("rst_scon", 8'h98, 8'h00, 1'b1);
    sfr_read("rst_sbuf", 8'h99, 8'h00, 1'b1);
    expect_pins("rst_pins", 1'b1, 1'b0);
    low_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) low_cnt++;
    end
    check("rst_tx_stays_idle", low_cnt[15:0], 16'd0);

    step();
    check("rd_queue_drained", 16'(rd_exp_q.size()), 16'd0);
    check("tx_queue_drained", 16'(tx_exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
